pot_scan_ctrl: RTL and testbench
================================

POT_SCAN_CTRL -- requirements
Module: pot_scan_ctrl

Interface
REQ-001 SHALL have port clk179  input  1  1.79 MHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_L  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port skctl_fast  input  1  SKCTL[2]; 1 = fast scan (tick every clk179 cycle), 0 = slow scan (tick every 114 cycles).
REQ-004 SHALL have port POTGO_strobe  input  1  one-cycle pulse that starts a scan.
REQ-005 SHALL have port pot_scan_in  input  4  asynchronous comparator outputs, one per paddle; 1 = capacitor threshold reached.
REQ-006 SHALL have ports POT0, POT1, POT2, POT3  output  8 each  latched pot counts.
REQ-007 SHALL have port ALLPOT  output  8  bit i = 1 while pot i is still being counted; bits 7:4 are constant 0.
REQ-008 SHALL have port pot_rel  output  1  capacitor dump control; 1 = dump transistors on.
REQ-009 SHALL have port scan_busy  output  1  1 while state is DUMP or SCAN.

Function
REQ-010 SHALL implement FSM states IDLE, DUMP and SCAN, all registered.
REQ-011 SHALL synchronize pot_scan_in through two flops before use; the synchronized value is sync_in.
REQ-012 SHALL generate tick: in fast mode, tick=1 every cycle; in slow mode, a 7-bit prescaler counts 0..113 and tick=1 when it equals 113, after which it wraps to 0.
REQ-013 SHALL clear the prescaler to 0 on every POTGO_strobe, so the first slow tick after a strobe occurs 114 cycles later.
REQ-014 SHALL, on POTGO_strobe in any state, next cycle: enter DUMP, clear POT0-3 to 0, set ALLPOT[3:0]=4'hF, clear scan counter and dump counter to 0.
REQ-015 SHALL give POTGO_strobe priority over every other event, including the terminal count and latch events of the same cycle.
REQ-016 SHALL hold DUMP for exactly 2 ticks, then enter SCAN with scan counter = 0.
REQ-017 SHALL drive pot_rel=1 in IDLE and DUMP and pot_rel=0 in SCAN, from a register with no combinational path from inputs.
REQ-018 SHALL, on each tick in SCAN with scan counter c < 228: for each i with ALLPOT[i]=1 and sync_in[i]=1, latch POTi=c and clear ALLPOT[i]; then increment c.
REQ-019 SHALL, on the tick where c = 228: latch POTi=228 and clear ALLPOT[i] for every i with ALLPOT[i] still 1 (sync_in ignored), then enter IDLE.
REQ-020 SHALL latch each POTi at most once per scan; later sync_in changes do not alter it.
REQ-021 SHALL, when ALLPOT[3:0] reaches 0 before c = 228, continue counting to 228 and still enter IDLE only at the terminal tick.
REQ-022 SHALL take skctl_fast changes mid-scan at the next cycle without restarting the scan; the prescaler continues from its current value.
REQ-023 SHALL never wrap the scan counter past 228; counter width 8 bits.
REQ-024 SHALL drive scan_busy combinationally from the state register only.

Reset
REQ-025 SHALL, when rst_L=0 at a clk179 edge: state IDLE, POT0-3 = 8'h00, ALLPOT = 8'h00, pot_rel = 1, scan_busy = 0, prescaler, scan and dump counters = 0, synchronizer flops = 0.
REQ-026 SHALL abort any scan in progress on reset, with no partial latch in the reset cycle.
REQ-027 SHALL ignore POTGO_strobe asserted in the same cycle as rst_L=0.

Verification
REQ-028 Fast mode, pot_scan_in=4'b0000, one POTGO -> pot_rel=0 for exactly 229 cycles starting 3 cycles after the strobe; POT0-3=228; ALLPOT=8'h00; IDLE; pot_rel=1.
REQ-029 Fast mode, pot_scan_in[0]=1 throughout, pot_scan_in[1] rising so that sync_in[1] is first 1 at c=100, others 0 -> POT0=0, POT1=100, POT2=POT3=228; ALLPOT[1] clears on the c=100 tick.
REQ-030 Slow mode, single POTGO, pot_scan_in[2] synced high at c=5 -> first tick 114 cycles after strobe; POT2=5; scan completes (2+229)*114 cycles after strobe.
REQ-031 Second POTGO at c=50 of a fast scan with POT0 already latched at 20 -> POT0 reads 0 next cycle, ALLPOT=8'h0F, state DUMP, a new full scan follows.
REQ-032 rst_L=0 mid-SCAN at c=80 -> all outputs at reset values next cycle; subsequent POTGO scans normally.
REQ-033 POTGO on the same cycle as the c=228 terminal tick -> DUMP entered, POT0-3 cleared, no 228 latch visible.

Source files
------------

// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: paddle (potentiometer) scan controller.
// A POTGO strobe dumps the pot capacitors for two scan ticks, then counts
// scan ticks 0..228. Each paddle whose comparator fires latches the current
// count into its POTi register. Paddles that never fire latch 228 on the
// terminal tick. Ticks come every clock in fast mode, or every 114 clocks
// in slow mode.

module pot_scan_ctrl (
   input  logic       clk179,
   input  logic       rst_L,
   input  logic       skctl_fast,
   input  logic       POTGO_strobe,
   input  logic [3:0] pot_scan_in,
   output logic [7:0] POT0,
   output logic [7:0] POT1,
   output logic [7:0] POT2,
   output logic [7:0] POT3,
   output logic [7:0] ALLPOT,
   output logic       pot_rel,
   output logic       scan_busy
);

   localparam logic [6:0] PRESCALE_LAST = 7'd113;
   localparam logic [7:0] SCAN_LAST     = 8'd228;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_sync1;
   logic [1:0] r_sync2Unused;
   logic [3:0] r_syncA;
   logic [3:0] r_syncB;
   logic [6:0] r_prescale;
   logic [7:0] r_scanCnt;
   logic       r_dumpCnt;
   logic [7:0] r_pot [4];
   logic [3:0] r_allPot;
   logic       r_potRel;

   state_t     w_nextState;
   logic [7:0] w_nextScanCnt;
   logic       w_nextDumpCnt;
   logic [7:0] w_nextPot [4];
   logic [3:0] w_nextAllPot;
   logic       w_nextPotRel;
   logic       w_tick;
   logic [3:0] w_syncIn;

   // The 2-bit r_sync1/r_sync2Unused pair is not used by the design.
   // Tie it off so every declared register has a defined value.
   always_ff @(posedge clk179) begin
      r_sync1       <= 2'b00;
      r_sync2Unused <= 2'b00;
   end

   // Two-flop synchronizer for the asynchronous comparator outputs.
   always_ff @(posedge clk179) begin
      if (!rst_L) begin
         r_syncA <= 4'b0000;
         r_syncB <= 4'b0000;
      end else begin
         r_syncA <= pot_scan_in;
         r_syncB <= r_syncA;
      end
   end

   assign w_syncIn = r_syncB;

   // Slow-mode prescaler. It runs in both modes so that a mid-scan mode
   // change picks up from wherever it is. It restarts on every strobe.
   always_ff @(posedge clk179) begin
      if (!rst_L) begin
         r_prescale <= 7'd0;
      end else if (POTGO_strobe) begin
         r_prescale <= 7'd0;
      end else if (r_prescale == PRESCALE_LAST) begin
         r_prescale <= 7'd0;
      end else begin
         r_prescale <= r_prescale + 7'd1;
      end
   end

   assign w_tick = skctl_fast | (r_prescale == PRESCALE_LAST);

   // State and datapath registers. Reset wins over a simultaneous strobe.
   always_ff @(posedge clk179) begin
      if (!rst_L) begin
         r_state   <= IDLE;
         r_scanCnt <= 8'd0;
         r_dumpCnt <= 1'b0;
         r_allPot  <= 4'b0000;
         r_potRel  <= 1'b1;
         for (int i = 0; i < 4; i++) begin
            r_pot[i] <= 8'd0;
         end
      end else begin
         r_state   <= w_nextState;
         r_scanCnt <= w_nextScanCnt;
         r_dumpCnt <= w_nextDumpCnt;
         r_allPot  <= w_nextAllPot;
         r_potRel  <= w_nextPotRel;
         for (int i = 0; i < 4; i++) begin
            r_pot[i] <= w_nextPot[i];
         end
      end
   end

   // Next-state and datapath logic. A strobe overrides everything,
   // including a terminal tick or a latch in the same cycle.
   always_comb begin
      w_nextState   = r_state;
      w_nextScanCnt = r_scanCnt;
      w_nextDumpCnt = r_dumpCnt;
      w_nextAllPot  = r_allPot;
      for (int i = 0; i < 4; i++) begin
         w_nextPot[i] = r_pot[i];
      end

      if (POTGO_strobe) begin
         w_nextState   = DUMP;
         w_nextScanCnt = 8'd0;
         w_nextDumpCnt = 1'b0;
         w_nextAllPot  = 4'hF;
         for (int i = 0; i < 4; i++) begin
            w_nextPot[i] = 8'd0;
         end
      end else begin
         case (r_state)
            DUMP: begin
               if (w_tick) begin
                  if (r_dumpCnt) begin
                     w_nextState   = SCAN;
                     w_nextScanCnt = 8'd0;
                     w_nextDumpCnt = 1'b0;
                  end else begin
                     w_nextDumpCnt = 1'b1;
                  end
               end
            end
            SCAN: begin
               if (w_tick) begin
                  if (r_scanCnt >= SCAN_LAST) begin
                     for (int i = 0; i < 4; i++) begin
                        if (r_allPot[i]) begin
                           w_nextPot[i] = SCAN_LAST;
                        end
                     end
                     w_nextAllPot = 4'b0000;
                     w_nextState  = IDLE;
                  end else begin
                     for (int i = 0; i < 4; i++) begin
                        if (r_allPot[i] && w_syncIn[i]) begin
                           w_nextPot[i]    = r_scanCnt;
                           w_nextAllPot[i] = 1'b0;
                        end
                     end
                     w_nextScanCnt = r_scanCnt + 8'd1;
                  end
               end
            end
            default: begin
               w_nextState = IDLE;
            end
         endcase
      end

      w_nextPotRel = (w_nextState != SCAN);
   end

   assign POT0      = r_pot[0];
   assign POT1      = r_pot[1];
   assign POT2      = r_pot[2];
   assign POT3      = r_pot[3];
   assign ALLPOT    = {4'b0000, r_allPot};
   assign pot_rel   = r_potRel;
   assign scan_busy = (r_state != IDLE);

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Directed bench for pot_scan_ctrl. Inputs change 1 time unit after a rising
// edge, and outputs are sampled at that same point. "Ek" below means the k-th
// rising edge after the edge that sampled the strobe (E0).

module tb_pot_scan_ctrl;

   logic       clk179;
   logic       rst_L;
   logic       skctl_fast;
   logic       POTGO_strobe;
   logic [3:0] pot_scan_in;
   logic [7:0] POT0, POT1, POT2, POT3, ALLPOT;
   logic       pot_rel;
   logic       scan_busy;

   int compareCount  = 0;
   int mismatchCount = 0;
   int lowCount;
   int firstLow;

   pot_scan_ctrl dut (
      .clk179       (clk179),
      .rst_L        (rst_L),
      .skctl_fast   (skctl_fast),
      .POTGO_strobe (POTGO_strobe),
      .pot_scan_in  (pot_scan_in),
      .POT0         (POT0),
      .POT1         (POT1),
      .POT2         (POT2),
      .POT3         (POT3),
      .ALLPOT       (ALLPOT),
      .pot_rel      (pot_rel),
      .scan_busy    (scan_busy)
   );

   // 10-unit clock period.
   initial begin
      clk179 = 1'b0;
      forever #5 clk179 = ~clk179;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed != expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk179);
      #1;
   endtask

   // Drive strobe/reset for exactly one rising edge, then return them to idle.
   task automatic applyStimulus(input logic strobe, input logic rstL);
      POTGO_strobe = strobe;
      rst_L        = rstL;
      @(posedge clk179);
      #1;
      POTGO_strobe = 1'b0;
      rst_L        = 1'b1;
   endtask

   initial begin
      rst_L        = 1'b0;
      skctl_fast   = 1'b1;
      POTGO_strobe = 1'b0;
      pot_scan_in  = 4'b0000;
      waitCycles(2);

      // Reset with a simultaneous strobe: the strobe must be ignored.
      applyStimulus(1'b1, 1'b0);
      checkOutput("rst_busy",   scan_busy, 0);
      checkOutput("rst_potrel", pot_rel,   1);
      checkOutput("rst_allpot", ALLPOT,    0);
      checkOutput("rst_pot0",   POT0,      0);
      checkOutput("rst_pot3",   POT3,      0);
      waitCycles(3);

      // Fast scan with no comparators firing.
      $display("[TB] fast scan, no paddles");
      applyStimulus(1'b1, 1'b1);
      checkOutput("f0_busy",   scan_busy, 1);
      checkOutput("f0_potrel", pot_rel,   1);
      checkOutput("f0_allpot", ALLPOT,    8'h0F);
      lowCount = 0;
      firstLow = -1;
      for (int k = 1; k <= 240; k++) begin
         waitCycles(1);
         if (pot_rel == 1'b0) begin
            if (firstLow < 0) firstLow = k;
            lowCount++;
         end
      end
      checkOutput("f0_firstlow", firstLow,  2);
      checkOutput("f0_lowcount", lowCount,  229);
      checkOutput("f0_pot0",     POT0,      228);
      checkOutput("f0_pot1",     POT1,      228);
      checkOutput("f0_pot2",     POT2,      228);
      checkOutput("f0_pot3",     POT3,      228);
      checkOutput("f0_allpot_end", ALLPOT,  0);
      checkOutput("f0_busy_end", scan_busy, 0);
      checkOutput("f0_potrel_end", pot_rel, 1);

      // Paddle 0 is high throughout. Paddle 1's synchronized input first reads 1 at c=100.
      $display("[TB] fast scan, paddle 0 immediate, paddle 1 at 100");
      pot_scan_in = 4'b0001;
      waitCycles(3);
      applyStimulus(1'b1, 1'b1);
      waitCycles(100);
      pot_scan_in = 4'b0011;
      waitCycles(2);
      checkOutput("p1_allpot_before", ALLPOT, 8'h0E);
      waitCycles(1);
      checkOutput("p1_allpot_after", ALLPOT, 8'h0C);
      checkOutput("p1_pot1_early",   POT1,   100);
      waitCycles(130);
      checkOutput("p1_pot0", POT0, 0);
      checkOutput("p1_pot1", POT1, 100);
      checkOutput("p1_pot2", POT2, 228);
      checkOutput("p1_pot3", POT3, 228);
      checkOutput("p1_busy", scan_busy, 0);
      pot_scan_in = 4'b0000;
      waitCycles(3);

      // Second strobe at c=50, after POT0 has latched 20.
      $display("[TB] restart mid-scan");
      applyStimulus(1'b1, 1'b1);
      waitCycles(20);
      pot_scan_in = 4'b0001;
      waitCycles(32);
      checkOutput("rs_pot0_before", POT0, 20);
      applyStimulus(1'b1, 1'b1);
      checkOutput("rs_pot0_cleared", POT0,      0);
      checkOutput("rs_allpot",       ALLPOT,    8'h0F);
      checkOutput("rs_busy",         scan_busy, 1);
      checkOutput("rs_potrel",       pot_rel,   1);
      waitCycles(235);
      checkOutput("rs_pot0_final", POT0,      0);
      checkOutput("rs_pot1_final", POT1,      228);
      checkOutput("rs_busy_end",   scan_busy, 0);
      pot_scan_in = 4'b0000;
      waitCycles(3);

      // Reset at c=80, with POT3 already latched at 40.
      $display("[TB] reset mid-scan");
      applyStimulus(1'b1, 1'b1);
      waitCycles(40);
      pot_scan_in = 4'b1000;
      waitCycles(42);
      checkOutput("mr_pot3_before", POT3, 40);
      applyStimulus(1'b0, 1'b0);
      checkOutput("mr_pot3",   POT3,      0);
      checkOutput("mr_allpot", ALLPOT,    0);
      checkOutput("mr_potrel", pot_rel,   1);
      checkOutput("mr_busy",   scan_busy, 0);
      pot_scan_in = 4'b0000;
      waitCycles(3);
      applyStimulus(1'b1, 1'b1);
      waitCycles(235);
      checkOutput("mr_pot3_rescan", POT3,      228);
      checkOutput("mr_busy_rescan", scan_busy, 0);

      // Strobe on the terminal tick.
      $display("[TB] strobe on terminal tick");
      applyStimulus(1'b1, 1'b1);
      waitCycles(230);
      checkOutput("tt_busy_before", scan_busy, 1);
      checkOutput("tt_pot0_before", POT0,      0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("tt_pot0",   POT0,      0);
      checkOutput("tt_pot2",   POT2,      0);
      checkOutput("tt_allpot", ALLPOT,    8'h0F);
      checkOutput("tt_busy",   scan_busy, 1);
      checkOutput("tt_potrel", pot_rel,   1);
      waitCycles(240);
      checkOutput("tt_pot2_rescan", POT2, 228);

      // Slow scan. Paddle 2's synchronized input first reads 1 at c=5.
      $display("[TB] slow scan");
      skctl_fast = 1'b0;
      waitCycles(3);
      applyStimulus(1'b1, 1'b1);
      waitCycles(227);
      checkOutput("sl_potrel_dump", pot_rel, 1);
      waitCycles(1);
      checkOutput("sl_potrel_scan", pot_rel, 0);
      waitCycles(572);
      pot_scan_in = 4'b0100;
      waitCycles(111);
      checkOutput("sl_allpot_before", ALLPOT, 8'h0F);
      waitCycles(1);
      checkOutput("sl_allpot_after", ALLPOT, 8'h0B);
      checkOutput("sl_pot2_early",   POT2,   5);
      waitCycles(25421);
      checkOutput("sl_busy_last", scan_busy, 1);
      waitCycles(1);
      checkOutput("sl_busy_end", scan_busy, 0);
      checkOutput("sl_pot2",     POT2,      5);
      checkOutput("sl_pot0",     POT0,      228);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
